// File: rtl/wb_lsu_master_if.sv
// wb_lsu_master_if
//
// Bundles every non-clock, non-reset signal of the load/store unit: the
// core-side request/response handshake and the Wishbone-style bus towards
// the data memory responder. Signal names keep their i_/o_ prefixes so that
// each name still shows its direction as seen from the LSU.
//
// Modports:
//   master - the LSU itself (drives o_*, samples i_*)
//   slave  - the environment: execute stage plus data memory responder
//            (drives i_*, samples o_*)
//
// Core side:
//   i_req      request strobe, only looked at while the LSU is idle
//   i_we       1 = store, 0 = load
//   i_funct3   size/extension code (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   i_addr     byte address
//   i_wdata    right-aligned store data
//   o_busy     transfer in progress
//   o_done     one-cycle pulse, transfer completed
//   o_err      one-cycle pulse, transfer rejected or aborted
//   o_rdata    registered load result
// Bus side:
//   o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel  request towards memory
//   i_wb_data, i_wb_ack, i_wb_stall                    response from memory
interface wb_lsu_master_if;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;

  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [2:0]  o_wb_sel;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;

  modport master (
    input  i_req, i_we, i_funct3, i_addr, i_wdata,
    output o_busy, o_done, o_err, o_rdata,
    output o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_data, i_wb_ack, i_wb_stall
  );

  modport slave (
    output i_req, i_we, i_funct3, i_addr, i_wdata,
    input  o_busy, o_done, o_err, o_rdata,
    input  o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_data, i_wb_ack, i_wb_stall
  );
endinterface

// File: rtl/wb_lsu_master.sv
// wb_lsu_master
//
// Load/store unit that turns one core request at a time into a single
// Wishbone-style transfer towards the data memory. It raises the strobe,
// holds the request stable while the responder stalls, waits for the
// acknowledge and hands load data back to the core. A watchdog aborts the
// transfer with an error if the acknowledge never arrives.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles waited for ack after acceptance before aborting
//                   (1..65535)
//   CNT_W           watchdog counter width, must be able to hold
//                   TIMEOUT_CYCLES
//
// Ports:
//   i_clk    clock, everything on the rising edge
//   i_reset  asynchronous active-high reset
//   bus      wb_lsu_master_if.master, core handshake plus memory bus
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests are rejected with o_err and
//               never reach the bus
//   undefined - addresses are passed to the bus exactly as given
//
// Timing: every output is a register. A new request is sampled in S_IDLE,
// the strobe appears the next cycle, and the done/err pulse is raised from
// S_RESP, so the minimum request-to-done latency is four clock edges.
module wb_lsu_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input logic              i_clk,
  input logic              i_reset,
  wb_lsu_master_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  // Watchdog value seen on the last allowed waiting cycle.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] watchdog;
  logic             resp_err;

  logic             legal_f3;
  logic             store_ok;
  logic             misalign;
  logic             reject;

  // Only the five RISC-V load encodings are meaningful here; the rest
  // (011, 110, 111) would need a 64-bit or nonexistent access.
  always_comb begin
    legal_f3 = 1'b0;
    case (bus.i_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
      default:                                legal_f3 = 1'b0;
    endcase
  end

  // Stores have no sign/zero extension, so the unsigned variants make no
  // sense for them and are treated as illegal.
  assign store_ok = !(bus.i_we && bus.i_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords must sit on an even address, words on a multiple of four.
  assign misalign = ((bus.i_funct3[1:0] == 2'b01) && bus.i_addr[0]) ||
                    ((bus.i_funct3[1:0] == 2'b10) && (bus.i_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject = !legal_f3 || !store_ok || misalign;

  // Single transfer FSM. o_done/o_err default low every cycle so that they
  // only ever last one cycle. The async reset drops the strobe at once and
  // never produces a completion pulse for the abandoned transfer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= S_IDLE;
      watchdog      <= '0;
      resp_err      <= 1'b0;
      bus.o_busy    <= 1'b0;
      bus.o_done    <= 1'b0;
      bus.o_err     <= 1'b0;
      bus.o_rdata   <= 32'h0;
      bus.o_wb_stb  <= 1'b0;
      bus.o_wb_we   <= 1'b0;
      bus.o_wb_addr <= 32'h0;
      bus.o_wb_data <= 32'h0;
      bus.o_wb_sel  <= 3'b010;
    end else begin
      bus.o_done <= 1'b0;
      bus.o_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.i_req) begin
            if (reject) begin
              bus.o_err <= 1'b1;
            end else begin
              bus.o_wb_we   <= bus.i_we;
              bus.o_wb_addr <= bus.i_addr;
              bus.o_wb_data <= bus.i_wdata;
              bus.o_wb_sel  <= bus.i_we ? {1'b0, bus.i_funct3[1:0]} : bus.i_funct3;
              bus.o_wb_stb  <= 1'b1;
              bus.o_busy    <= 1'b1;
              state         <= S_REQ;
            end
          end
        end

        // The strobe is always high here, so acceptance is simply the
        // absence of stall. Stall may last forever; only the ack wait is
        // guarded. An ack arriving before acceptance is meaningless.
        S_REQ: begin
          if (!bus.i_wb_stall) begin
            bus.o_wb_stb <= 1'b0;
            watchdog     <= '0;
            state        <= S_WAIT;
          end
        end

        // Ack is tested before the watchdog so that an ack landing on the
        // very last allowed cycle still counts as a success.
        S_WAIT: begin
          if (bus.i_wb_ack) begin
            if (!bus.o_wb_we) begin
              bus.o_rdata <= bus.i_wb_data;
            end
            resp_err <= 1'b0;
            state    <= S_RESP;
          end else if (watchdog == WD_LAST) begin
            resp_err <= 1'b1;
            state    <= S_RESP;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        S_RESP: begin
          if (resp_err) begin
            bus.o_err <= 1'b1;
          end else begin
            bus.o_done <= 1'b1;
          end
          bus.o_busy <= 1'b0;
          resp_err   <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          bus.o_wb_stb <= 1'b0;
          bus.o_busy   <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb_wb_lsu_master
//
// Self-checking bench for wb_lsu_master built with TIMEOUT_CYCLES=8.
// A table of directed transfers is played through a small scripted
// responder (stall count, ack delay, read data per row), followed by
// hand-written sequences for reset, spurious ack and async reset in the
// middle of a transfer. Rows whose outcome depends on
// LSU_MISALIGN_TRAP_EN pick their expectations from the same macro.
//
// Latency is counted in rising edges, the edge that samples i_req being
// edge 1; o_done/o_err is looked at 1 ns after each edge.
module tb_wb_lsu_master;

  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;

  int checks;
  int failures;
  logic [31:0] rdata_model;

  wb_lsu_master_if bus ();

  wb_lsu_master #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(16)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    int          ack_delay;
    logic [31:0] bus_data;
    logic        noise;
    logic        exp_err;
    logic        exp_bus;
    logic [2:0]  exp_sel;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic we, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input int stall, input int ack_delay,
    input logic [31:0] bus_data, input logic noise, input logic exp_err,
    input logic exp_bus, input logic [2:0] exp_sel, input int exp_lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.stall = stall; v.ack_delay = ack_delay; v.bus_data = bus_data;
    v.noise = noise; v.exp_err = exp_err; v.exp_bus = exp_bus;
    v.exp_sel = exp_sel; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Runs one transfer: drives the request, plays the responder according
  // to the row, then checks outcome, latency, bus fields and o_rdata.
  task automatic apply_stimulus(input vec_t v, input string tag);
    int          lat;
    int          stall_left;
    int          wait_cnt;
    logic        waiting;
    logic        pend;
    logic        saw_stb;
    logic        unstable;
    logic        busy_bad;
    logic        got_done;
    logic        got_err;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [2:0]  s_sel;
    logic        s_we;

    lat = 0; stall_left = v.stall; wait_cnt = 0;
    waiting = 1'b0; pend = 1'b0; saw_stb = 1'b0; unstable = 1'b0;
    busy_bad = 1'b0; got_done = 1'b0; got_err = 1'b0;
    s_addr = '0; s_data = '0; s_sel = '0; s_we = 1'b0;

    bus.i_we = v.we; bus.i_funct3 = v.f3; bus.i_addr = v.addr;
    bus.i_wdata = v.wdata; bus.i_wb_stall = 1'b0; bus.i_wb_ack = 1'b0;
    bus.i_req = 1'b1;

    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      lat++;
      bus.i_req = 1'b0;
      bus.i_wb_ack = 1'b0;
      bus.i_addr = v.addr;
      bus.i_wdata = v.wdata;
      if (bus.o_done || bus.o_err) begin
        got_done = bus.o_done;
        got_err = bus.o_err;
        break;
      end
      if (!bus.o_busy) busy_bad = 1'b1;
      if (pend) begin
        waiting = 1'b1;
        pend = 1'b0;
      end
      if (bus.o_wb_stb) begin
        if (!saw_stb) begin
          saw_stb = 1'b1;
          s_addr = bus.o_wb_addr; s_data = bus.o_wb_data;
          s_sel = bus.o_wb_sel; s_we = bus.o_wb_we;
        end else if (s_addr !== bus.o_wb_addr || s_data !== bus.o_wb_data ||
                     s_sel !== bus.o_wb_sel || s_we !== bus.o_wb_we) begin
          unstable = 1'b1;
        end
        if (stall_left > 0) begin
          bus.i_wb_stall = 1'b1;
          stall_left--;
        end else begin
          bus.i_wb_stall = 1'b0;
          pend = 1'b1;
        end
        if (v.noise) begin
          bus.i_wb_ack = 1'b1;
          bus.i_wb_data = 32'hBAD0BAD0;
        end
      end else begin
        bus.i_wb_stall = 1'b0;
      end
      if (waiting) begin
        if (v.ack_delay >= 0 && wait_cnt == v.ack_delay) begin
          bus.i_wb_ack = 1'b1;
          bus.i_wb_data = v.bus_data;
        end
        wait_cnt++;
      end
      if (v.noise && bus.o_busy) begin
        bus.i_req = 1'b1;
        bus.i_addr = ~v.addr;
        bus.i_wdata = ~v.wdata;
      end
    end
    bus.i_req = 1'b0; bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;
    bus.i_addr = v.addr; bus.i_wdata = v.wdata;

    if (!got_done && !got_err) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout no done/err within 40 cycles actual=0 expected=1", tag);
    end

    if (!v.exp_err && !v.we) rdata_model = v.bus_data;

    check_output({tag, "_done"}, 32'(got_done), 32'(!v.exp_err));
    check_output({tag, "_err"}, 32'(got_err), 32'(v.exp_err));
    check_output({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
    check_output({tag, "_stb_seen"}, 32'(saw_stb), 32'(v.exp_bus));
    check_output({tag, "_busy_during"}, 32'(busy_bad), 32'h0);
    check_output({tag, "_busy_end"}, 32'(bus.o_busy), 32'h0);
    if (v.exp_bus) begin
      check_output({tag, "_addr"}, s_addr, v.addr);
      check_output({tag, "_sel"}, 32'(s_sel), 32'(v.exp_sel));
      check_output({tag, "_we"}, 32'(s_we), 32'(v.we));
      if (v.we) check_output({tag, "_wdata"}, s_data, v.wdata);
      check_output({tag, "_stable"}, 32'(unstable), 32'h0);
    end
    check_output({tag, "_rdata"}, bus.o_rdata, rdata_model);

    @(posedge clk); #1;
    check_output({tag, "_pulse_end"}, {30'h0, bus.o_done, bus.o_err}, 32'h0);
    check_output({tag, "_idle_after"}, {30'h0, bus.o_busy, bus.o_wb_stb}, 32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rdata_model = 32'h0;
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_funct3 = 3'b010;
    bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_wb_data = '0; bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;

    //              we    f3      addr          wdata         stl ack bus_data      nz  err   bus   sel     lat
    vecs[0]  = mk(1'b1, 3'b010, 32'h10,       32'hDEADBEEF,  0,  0, 32'h0,        0, 1'b0, 1'b1, 3'b010,  4);
    vecs[1]  = mk(1'b0, 3'b010, 32'h10,       32'h0,         0,  0, 32'hDEADBEEF, 0, 1'b0, 1'b1, 3'b010,  4);
    vecs[2]  = mk(1'b0, 3'b000, 32'h80,       32'h0,         0,  0, 32'hFFFFFFF0, 0, 1'b0, 1'b1, 3'b000,  4);
    vecs[3]  = mk(1'b0, 3'b100, 32'h80,       32'h0,         0,  0, 32'h000000F0, 0, 1'b0, 1'b1, 3'b100,  4);
    vecs[4]  = mk(1'b0, 3'b101, 32'h42,       32'h0,         3,  0, 32'h0000BEEF, 1, 1'b0, 1'b1, 3'b101,  7);
    vecs[5]  = mk(1'b1, 3'b001, 32'h44,       32'h00001234,  0,  2, 32'h0,        0, 1'b0, 1'b1, 3'b001,  6);
    vecs[6]  = mk(1'b0, 3'b011, 32'h48,       32'h0,         0,  0, 32'h0,        0, 1'b1, 1'b0, 3'b000,  1);
    vecs[7]  = mk(1'b0, 3'b110, 32'h48,       32'h0,         0,  0, 32'h0,        0, 1'b1, 1'b0, 3'b000,  1);
    vecs[8]  = mk(1'b1, 3'b100, 32'h48,       32'h000000AA,  0,  0, 32'h0,        0, 1'b1, 1'b0, 3'b000,  1);
    vecs[9]  = mk(1'b0, 3'b010, 32'h100,      32'h0,         0, -1, 32'h0,        0, 1'b1, 1'b1, 3'b010, 11);
    vecs[10] = mk(1'b0, 3'b010, 32'h104,      32'h0,         0,  7, 32'h55AA55AA, 0, 1'b0, 1'b1, 3'b010, 11);
    vecs[11] = mk(1'b0, 3'b010, 32'h108,      32'h0,         0,  8, 32'h77777777, 0, 1'b1, 1'b1, 3'b010, 11);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[12] = mk(1'b0, 3'b010, 32'h22,       32'h0,         0,  0, 32'h11223344, 0, 1'b1, 1'b0, 3'b010,  1);
    vecs[13] = mk(1'b0, 3'b001, 32'h43,       32'h0,         0,  0, 32'hFFFF8001, 0, 1'b1, 1'b0, 3'b001,  1);
`else
    vecs[12] = mk(1'b0, 3'b010, 32'h22,       32'h0,         0,  0, 32'h11223344, 0, 1'b0, 1'b1, 3'b010,  4);
    vecs[13] = mk(1'b0, 3'b001, 32'h43,       32'h0,         0,  0, 32'hFFFF8001, 0, 1'b0, 1'b1, 3'b001,  4);
`endif
    vecs[14] = mk(1'b1, 3'b000, 32'h203,      32'h0000005A,  1,  1, 32'h0,        0, 1'b0, 1'b1, 3'b000,  6);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst_busy", 32'(bus.o_busy), 32'h0);
    check_output("rst_done_err", {30'h0, bus.o_done, bus.o_err}, 32'h0);
    check_output("rst_rdata", bus.o_rdata, 32'h0);
    check_output("rst_stb_we", {30'h0, bus.o_wb_stb, bus.o_wb_we}, 32'h0);
    check_output("rst_addr", bus.o_wb_addr, 32'h0);
    check_output("rst_wdata", bus.o_wb_data, 32'h0);
    check_output("rst_sel", 32'(bus.o_wb_sel), 32'h2);
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Spurious ack while idle must do nothing.
    bus.i_wb_ack = 1'b1;
    bus.i_wb_data = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_output($sformatf("spur_ack_%0d", k),
                   {29'h0, bus.o_busy, bus.o_done, bus.o_err}, 32'h0);
    end
    bus.i_wb_ack = 1'b0;
    check_output("spur_ack_rdata", bus.o_rdata, rdata_model);

    // Async reset while the strobe is held by stall.
    bus.i_we = 1'b0; bus.i_funct3 = 3'b010; bus.i_addr = 32'h200;
    bus.i_wb_stall = 1'b1; bus.i_req = 1'b1;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    check_output("rreq_stb_before", 32'(bus.o_wb_stb), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_output("rreq_stb_async", 32'(bus.o_wb_stb), 32'h0);
    check_output("rreq_busy_async", 32'(bus.o_busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_wb_stall = 1'b0;
    rdata_model = 32'h0;

    // Async reset while waiting for ack.
    bus.i_addr = 32'h204; bus.i_req = 1'b1;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    @(posedge clk); #1;
    check_output("rwait_stb_before", {30'h0, bus.o_busy, bus.o_wb_stb}, 32'h2);
    #2 rst = 1'b1;
    #1;
    check_output("rwait_busy_async", {30'h0, bus.o_busy, bus.o_wb_stb}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_wb_ack = 1'b1;
    bus.i_wb_data = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus.i_wb_ack = 1'b0;
      check_output($sformatf("rwait_quiet_%0d", k),
                   {29'h0, bus.o_busy, bus.o_done, bus.o_err}, 32'h0);
    end
    check_output("rwait_rdata", bus.o_rdata, 32'h0);

    // Normal transfer after the reset.
    apply_stimulus(mk(1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'hA5A5A5A5, 0,
                      1'b0, 1'b1, 3'b010, 4), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
